// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one synchronous DRAM between NUM_CORES cores
//
// Purpose: grants one requesting core at a time (round-robin, last-served core
// lowest priority), drives the DRAM address/write port for that core, captures
// read data after MEM_LAT cycles and pulses a one-hot acknowledge.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   core_req/core_we        per-core request level and write flag
//   core_addr/core_wdata    packed per-core address and write data
//   core_ack                one-hot single-cycle completion pulse
//   core_rdata              read data, valid while core_ack is high
//   grant_id, busy          served core index, transaction in progress
//   mem_addr/mem_we/mem_wdata/mem_rdata   DRAM interface
module dram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [2:0]                  grant_id,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                 state_q;
    logic [2:0]             last_q;
    logic [2:0]             grant_q;
    logic [7:0]             cnt_q;
    logic                   we_q;
    logic [NUM_CORES-1:0]   ack_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   mem_we_q;
    logic                   busy_q;

    // Round-robin pick: the lowest requester above last_q wins; if none, the
    // lowest requester at or below last_q (wraparound, last_q itself last).
    logic [2:0]             sel_d;
    logic                   hi_found;
    logic [2:0]             hi_idx;
    logic [2:0]             lo_idx;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req[i]) begin
                if (3'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end else begin
                    lo_idx   = 3'(i);
                end
            end
        end
        sel_d = hi_found ? hi_idx : lo_idx;
    end

    logic [ADDR_W-1:0]      addr_d;
    logic [DATA_W-1:0]      wdata_d;
    logic                   we_d;
    logic [NUM_CORES-1:0]   ack_onehot;

    always_comb begin
        addr_d     = '0;
        wdata_d    = '0;
        we_d       = 1'b0;
        ack_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_d == 3'(i)) begin
                addr_d  = core_addr[i*ADDR_W +: ADDR_W];
                wdata_d = core_wdata[i*DATA_W +: DATA_W];
                we_d    = core_we[i];
            end
            ack_onehot[i] = (grant_q == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 3'(NUM_CORES - 1);
            grant_q  <= 3'd0;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|core_req) begin
                        grant_q  <= sel_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        we_q     <= we_d;
                        mem_we_q <= we_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // DRAM samples address/data/we on this edge.
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        ack_q   <= ack_onehot;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q   <= 8'(MEM_LAT - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        rdata_q <= mem_rdata;
                        ack_q   <= ack_onehot;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q   <= '0;
                    last_q  <= grant_q;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_ack   = ack_q;
    assign core_rdata = rdata_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign mem_addr   = addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter
module tb_dram_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_we;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;

    logic [N-1:0]    d1_ack,   d3_ack;
    logic [DW-1:0]   d1_rdata, d3_rdata;
    logic [2:0]      d1_grant, d3_grant;
    logic            d1_busy,  d3_busy;
    logic [AW-1:0]   d1_maddr, d3_maddr;
    logic            d1_mwe,   d3_mwe;
    logic [DW-1:0]   d1_mwd,   d3_mwd;
    logic [DW-1:0]   d1_mrd,   d3_mrd;

    dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(d1_ack),
        .core_rdata(d1_rdata), .grant_id(d1_grant), .busy(d1_busy),
        .mem_addr(d1_maddr), .mem_we(d1_mwe), .mem_wdata(d1_mwd), .mem_rdata(d1_mrd)
    );

    dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(d3_ack),
        .core_rdata(d3_rdata), .grant_id(d3_grant), .busy(d3_busy),
        .mem_addr(d3_maddr), .mem_we(d3_mwe), .mem_wdata(d3_mwd), .mem_rdata(d3_mrd)
    );

    // Memory models: latency 1 and latency 3 synchronous DRAMs, plus a preload port.
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] mem1 [0:4095];
    logic [DW-1:0] mem3 [0:4095];
    logic [DW-1:0] p1, p3a, p3b, p3c;

    always @(posedge clk) begin
        if (pre_we) mem1[pre_addr] <= pre_data;
        else if (d1_mwe) mem1[d1_maddr] <= d1_mwd;
        p1 <= mem1[d1_maddr];
    end
    assign d1_mrd = p1;

    always @(posedge clk) begin
        if (pre_we) mem3[pre_addr] <= pre_data;
        else if (d3_mwe) mem3[d3_maddr] <= d3_mwd;
        p3a <= mem3[d3_maddr];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign d3_mrd = p3c;

    logic          use3 = 1'b0;
    logic [N-1:0]  ack_s;
    logic [DW-1:0] rdata_s, mwd_s;
    logic [2:0]    grant_s;
    logic          busy_s, mwe_s;
    logic [AW-1:0] maddr_s;
    assign ack_s   = use3 ? d3_ack   : d1_ack;
    assign rdata_s = use3 ? d3_rdata : d1_rdata;
    assign grant_s = use3 ? d3_grant : d1_grant;
    assign busy_s  = use3 ? d3_busy  : d1_busy;
    assign maddr_s = use3 ? d3_maddr : d1_maddr;
    assign mwe_s   = use3 ? d3_mwe   : d1_mwe;
    assign mwd_s   = use3 ? d3_mwd   : d1_mwd;

    int n_tests = 0;
    int n_fail = 0;
    int bad_onehot = 0;

    always @(negedge clk) begin
        if (!$onehot0(d1_ack) || !$onehot0(d3_ack)) bad_onehot <= bad_onehot + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we[i] = we;
        core_addr[i*AW +: AW] = a;
        core_wdata[i*DW +: DW] = d;
        core_req[i] = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Counts negedges after the driving negedge until an ack is seen; 99 on timeout.
    task automatic wait_ack(output int lat);
        lat = 99;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack_s != '0) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] a);
        idx_of = -1;
        for (int k = 0; k < N; k++) if (a[k]) idx_of = k;
    endfunction

    initial begin
        int lat;
        int got;
        int k;
        int we_cnt;
        int gid_bad;
        int other_acks;
        int order [N];
        int acks [N];
        logic [AW-1:0] wa [N];
        logic [DW-1:0] wd [N];
        int seq [6];
        logic [N-1:0] pend;

        rst_n = 1'b0;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;

        // Test 1: reset state, single read with latency 1
        use3 = 1'b0;
        preload(12'h005, 16'h1234);
        do_reset();
        check("rst_ack", ack_s, 0);
        check("rst_busy", busy_s, 0);
        check("rst_grant", grant_s, 0);
        check("rst_maddr", maddr_s, 0);
        check("rst_mwe", mwe_s, 0);
        check("rst_mwdata", mwd_s, 0);
        check("rst_rdata", rdata_s, 0);
        set_core(0, 1'b0, 12'h005, 16'h0000);
        @(negedge clk);
        check("t1_issue_addr", maddr_s, 12'h005);
        check("t1_issue_we", mwe_s, 0);
        check("t1_issue_busy", busy_s, 1);
        wait_ack(lat);
        check("t1_latency", lat + 1, 3);
        check("t1_ack", ack_s, 4'b0001);
        check("t1_rdata", rdata_s, 16'h1234);
        core_req[0] = 1'b0;
        @(negedge clk);
        check("t1_busy_after", busy_s, 0);
        check("t1_ack_after", ack_s, 0);

        // Test 2: four simultaneous writes served 0,1,2,3
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 12'h010 + 12'(i), 16'h00A0 + 16'(i));
        got = 0; we_cnt = 0; gid_bad = 0;
        for (int i = 0; i < N; i++) acks[i] = 0;
        for (int c = 0; c < 80 && got < N; c++) begin
            @(negedge clk);
            if (mwe_s) begin
                if (we_cnt < N) begin
                    wa[we_cnt] = maddr_s;
                    wd[we_cnt] = mwd_s;
                end
                we_cnt++;
            end
            if (ack_s != '0) begin
                k = idx_of(ack_s);
                order[got] = k;
                if (grant_s != 3'(k)) gid_bad++;
                acks[k]++;
                core_req[k] = 1'b0;
                got++;
            end
        end
        check("t2_ack_total", got, N);
        for (int i = 0; i < N; i++) begin
            check($sformatf("t2_order%0d", i), order[i], i);
            check($sformatf("t2_we_addr%0d", i), wa[i], 12'h010 + 12'(i));
            check($sformatf("t2_we_data%0d", i), wd[i], 16'h00A0 + 16'(i));
            check($sformatf("t2_ackcnt%0d", i), acks[i], 1);
        end
        check("t2_we_cycles", we_cnt, N);
        check("t2_grant_id", gid_bad, 0);

        // Test 3: cores 1 and 3 re-request continuously
        do_reset();
        set_core(1, 1'b0, 12'h100, 16'h0);
        set_core(3, 1'b0, 12'h300, 16'h0);
        got = 0; other_acks = 0; pend = '0;
        for (int c = 0; c < 120 && got < 6; c++) begin
            @(negedge clk);
            core_req = core_req | pend;
            pend = '0;
            if (ack_s != '0) begin
                k = idx_of(ack_s);
                seq[got] = k;
                if (k == 0 || k == 2) other_acks++;
                core_req[k] = 1'b0;
                pend[k] = 1'b1;
                got++;
            end
        end
        core_req = '0;
        check("t3_ack_total", got, 6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_seq%0d", i), seq[i], (i % 2 == 0) ? 1 : 3);
        check("t3_cores02", other_acks, 0);

        // Test 4: MEM_LAT=3 read, core0 request raised during WAIT served next
        use3 = 1'b1;
        preload(12'hFFF, 16'hBEEF);
        preload(12'h001, 16'h5555);
        do_reset();
        set_core(2, 1'b0, 12'hFFF, 16'h0);
        lat = 99;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 2) begin
                check("t4_busy_wait", busy_s, 1);
                set_core(0, 1'b0, 12'h001, 16'h0);
            end
            if (ack_s != '0) begin
                lat = c;
                break;
            end
        end
        check("t4_latency", lat, 5);
        check("t4_ack", ack_s, 4'b0100);
        check("t4_rdata", rdata_s, 16'hBEEF);
        core_req[2] = 1'b0;
        wait_ack(lat);
        check("t4_next_latency", lat, 6);
        check("t4_next_ack", ack_s, 4'b0001);
        check("t4_next_rdata", rdata_s, 16'h5555);
        core_req[0] = 1'b0;

        // Test 5: reset asserted mid-WAIT aborts, pointer returns to NUM_CORES-1
        use3 = 1'b0;
        do_reset();
        set_core(1, 1'b0, 12'h007, 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_pre", busy_s, 1);
        check("t5_grant_pre", grant_s, 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_busy", busy_s, 0);
        check("t5_async_ack", ack_s, 0);
        check("t5_async_grant", grant_s, 0);
        check("t5_async_maddr", maddr_s, 0);
        check("t5_async_mwe", mwe_s, 0);
        check("t5_async_rdata", rdata_s, 0);
        set_core(2, 1'b0, 12'h009, 16'h0);
        @(negedge clk);
        check("t5_ack_in_reset", ack_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(lat);
        check("t5_first_ack", ack_s, 4'b0010);
        core_req[1] = 1'b0;
        wait_ack(lat);
        check("t5_second_ack", ack_s, 4'b0100);
        core_req[2] = 1'b0;

        // Test 6: write then read back through the latency-1 DRAM
        do_reset();
        set_core(0, 1'b1, 12'h020, 16'h0123);
        wait_ack(lat);
        check("t6_wr_latency", lat, 2);
        check("t6_wr_ack", ack_s, 4'b0001);
        check("t6_wr_rdata_kept", rdata_s, 0);
        core_req[0] = 1'b0;
        @(negedge clk);
        set_core(0, 1'b0, 12'h020, 16'h0);
        wait_ack(lat);
        check("t6_rd_latency", lat, 3);
        check("t6_rd_rdata", rdata_s, 16'h0123);
        core_req[0] = 1'b0;
        @(negedge clk);

        check("onehot_ack", bad_onehot, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
